// File: rtl/cram_arbiter.sv
// cram_arbiter: N-channel round-robin arbiter and async-mode timing engine for a 16-bit cellular RAM.
// Optional macro CRAM_ARB_CH0_PRIORITY_EN gives channel 0 (VGA fetch) absolute priority.
module cram_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        we,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic [NUM_CH*DATA_W-1:0] wdata,
    output logic [NUM_CH-1:0]        ack,
    output logic [DATA_W-1:0]        rdata,
    output logic                     busy,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_dq_o,
    output logic                     mem_dq_oe,
    input  logic [DATA_W-1:0]        mem_dq_i,
    output logic                     mem_cs_n,
    output logic                     mem_adv_n,
    output logic                     mem_we_n,
    output logic                     mem_oe_n
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
`ifdef CRAM_ARB_CH0_PRIORITY_EN
    localparam logic [CH_W-1:0] PTR_RST = CH_W'(1);
`else
    localparam logic [CH_W-1:0] PTR_RST = '0;
`endif

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   win;
    logic              win_we;
    logic [CNT_W-1:0]  cnt;

    logic [NUM_CH-1:0] cand;
    logic              found;
    logic [CH_W-1:0]   pick;
    logic [CH_W:0]     scan;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;

    // Rotating scan starting at rr_ptr; with priority enabled channel 0 is taken out of the rotation.
    always_comb begin
        cand  = req;
        found = 1'b0;
        pick  = '0;
        scan  = '0;
`ifdef CRAM_ARB_CH0_PRIORITY_EN
        cand[0] = 1'b0;
        if (req[0])
            found = 1'b1;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            scan = {1'b0, rr_ptr} + (CH_W+1)'(k);
            if (scan >= (CH_W+1)'(NUM_CH))
                scan = scan - (CH_W+1)'(NUM_CH);
            if (!found && cand[scan[CH_W-1:0]]) begin
                found = 1'b1;
                pick  = scan[CH_W-1:0];
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick == CH_W'(i)) begin
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
                sel_we    = we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= PTR_RST;
            win       <= '0;
            win_we    <= 1'b0;
            cnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_dq_o  <= '0;
            mem_dq_oe <= 1'b0;
            mem_cs_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state     <= SETUP;
                        win       <= pick;
                        win_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_dq_o  <= sel_wdata;
                        mem_dq_oe <= sel_we;
                        mem_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SETUP: begin
                    state    <= ACCESS;
                    cnt      <= CNT_W'(WAIT_CYCLES - 1);
                    mem_we_n <= ~win_we;
                    mem_oe_n <= win_we;
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state    <= DONE;
                        mem_cs_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        mem_oe_n <= 1'b1;
                        ack      <= NUM_CH'(1) << win;
                        if (!win_we)
                            rdata <= mem_dq_i;
`ifdef CRAM_ARB_CH0_PRIORITY_EN
                        if (win != '0)
                            rr_ptr <= (win == CH_W'(NUM_CH - 1)) ? CH_W'(1) : win + CH_W'(1);
`else
                        rr_ptr <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + CH_W'(1);
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Write data stays driven through DONE as hold time.
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mem_dq_oe <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_adv_n = mem_cs_n;

endmodule

// File: tb/tb_cram_arbiter.sv
// tb_cram_arbiter: directed vectors, corner sequences and randomized traffic for cram_arbiter,
// checked against a transaction-level model with its own memory image.
module tb_cram_arbiter;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int W      = 7;
`ifdef CRAM_ARB_CH0_PRIORITY_EN
    localparam int PTR0 = 1;
`else
    localparam int PTR0 = 0;
`endif

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_CH-1:0]        req   = '0;
    logic [NUM_CH-1:0]        we    = '0;
    logic [NUM_CH*ADDR_W-1:0] addr  = '0;
    logic [NUM_CH*DATA_W-1:0] wdata = '0;
    logic [NUM_CH-1:0]        ack;
    logic [DATA_W-1:0]        rdata;
    logic                     busy;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_dq_o;
    logic                     mem_dq_oe;
    logic [DATA_W-1:0]        mem_dq_i = '0;
    logic                     mem_cs_n, mem_adv_n, mem_we_n, mem_oe_n;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cram_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_dq_o(mem_dq_o),
        .mem_dq_oe(mem_dq_oe), .mem_dq_i(mem_dq_i), .mem_cs_n(mem_cs_n), .mem_adv_n(mem_adv_n),
        .mem_we_n(mem_we_n), .mem_oe_n(mem_oe_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Device memory (what the RAM actually holds) and the model's expected memory image.
    logic [15:0] dev     [logic [23:0]];
    logic [15:0] exp_mem [logic [23:0]];

    function automatic logic [15:0] rd_dev(input logic [23:0] a);
        return dev.exists(a) ? dev[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] rd_exp(input logic [23:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : 16'h0000;
    endfunction

    function automatic int pick(input logic [3:0] r, input int ptr);
`ifdef CRAM_ARB_CH0_PRIORITY_EN
        if (r[0]) return 0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (ptr + k) % NUM_CH;
`ifdef CRAM_ARB_CH0_PRIORITY_EN
            if (c != 0 && r[c[1:0]]) return c;
`else
            if (r[c[1:0]]) return c;
`endif
        end
        return -1;
    endfunction

    function automatic int next_ptr(input int w, input int ptr);
`ifdef CRAM_ARB_CH0_PRIORITY_EN
        if (w == 0) return ptr;
        return (w % (NUM_CH - 1)) + 1;
`else
        return (w + 1) % NUM_CH;
`endif
    endfunction

    bit          m_active  = 1'b0;
    int          m_t, m_ch, md, mw;
    int          m_ptr     = PTR0;
    int          m_free    = 0;
    bit          m_we;
    logic [23:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_last_rd = '0;
    logic [3:0]  e_ack;
    logic        e_busy, e_cs, e_we_n, e_oe_n, e_dq_oe;

    // Cycle monitor: device RAM behaviour plus model-predicted pin and handshake values.
    always @(negedge clk) begin
        if (!mem_cs_n && !mem_we_n) dev[mem_addr] = mem_dq_o;
        mem_dq_i = mem_oe_n ? 16'($urandom) : rd_dev(mem_addr);
        if (!rst_n) begin
            m_active  = 1'b0;
            m_ptr     = PTR0;
            m_last_rd = '0;
            m_free    = 0;
        end else begin
            e_ack = '0; e_busy = 1'b0; e_cs = 1'b1; e_we_n = 1'b1; e_oe_n = 1'b1; e_dq_oe = 1'b0;
            md = m_active ? cyc - m_t : -1;
            if (m_active) begin
                e_busy = (md >= 1 && md <= W + 2);
                e_cs   = !(md >= 1 && md <= W + 1);
                if (md >= 2 && md <= W + 1) begin
                    if (m_we) e_we_n = 1'b0;
                    else      e_oe_n = 1'b0;
                end
                e_dq_oe = m_we && e_busy;
                if (md == W + 2) e_ack = 4'b0001 << m_ch;
            end
            check("pins", 64'({ack, busy, mem_cs_n, mem_adv_n, mem_we_n, mem_oe_n, mem_dq_oe}),
                  64'({e_ack, e_busy, e_cs, e_cs, e_we_n, e_oe_n, e_dq_oe}));
            if (m_active && md >= 1 && md <= W + 2) check("mem_addr", 64'(mem_addr), 64'(m_addr));
            if (m_active && m_we && md >= 1 && md <= W + 2) check("mem_dq_o", 64'(mem_dq_o), 64'(m_wdata));
            if (m_active && md == W + 2) begin
                if (m_we) exp_mem[m_addr] = m_wdata;
                else      m_last_rd = rd_exp(m_addr);
                m_active = 1'b0;
                m_free   = cyc + 1;
            end
            check("rdata", 64'(rdata), 64'(m_last_rd));
            if (!m_active && cyc >= m_free && req != '0) begin
                mw       = pick(req, m_ptr);
                m_active = 1'b1;
                m_t      = cyc;
                m_ch     = mw;
                m_we     = we[mw];
                m_addr   = addr[mw*ADDR_W +: ADDR_W];
                m_wdata  = wdata[mw*DATA_W +: DATA_W];
                m_ptr    = next_ptr(mw, m_ptr);
            end
        end
    end

    task automatic issue(input int ch, input bit wr, input logic [23:0] a, input logic [15:0] d);
        req = 4'b0001 << ch;
        we[ch] = wr;
        addr[ch*ADDR_W +: ADDR_W] = a;
        wdata[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic wait_ack(output logic [3:0] a, output int at, output bit ok);
        ok = 1'b0; a = '0; at = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (ack != '0) begin
                a = ack; at = cyc; ok = 1'b1;
            end
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 1'b0; req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        int          ch;
        bit          wr;
        logic [23:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        logic [3:0]  ack;
    } vec_t;

    vec_t        tbl [6];
    int          t0, lat, at, prev, n_oe, n_we, n_dq, nack;
    bit          seen, ok;
    logic [3:0]  got_ack, a;
    logic [15:0] got_rd, got_dq;
    bit   [3:0]  pend;
    int          exp_fair [5];
    int          exp_prio [4];

    initial begin
        dev[24'h001234] = 16'hBEEF;
        exp_mem[24'h001234] = 16'hBEEF;
        tbl[0] = '{2, 1'b0, 24'h001234, 16'h0000, 16'hBEEF, 4'b0100};
        tbl[1] = '{1, 1'b1, 24'h000010, 16'hA5A5, 16'hBEEF, 4'b0010};
        tbl[2] = '{0, 1'b0, 24'h000010, 16'h0000, 16'hA5A5, 4'b0001};
        tbl[3] = '{3, 1'b1, 24'hFFFFFF, 16'h5A5A, 16'hA5A5, 4'b1000};
        tbl[4] = '{3, 1'b0, 24'hFFFFFF, 16'h0000, 16'h5A5A, 4'b1000};
        tbl[5] = '{1, 1'b0, 24'h000000, 16'h0000, 16'h0000, 4'b0010};
`ifdef CRAM_ARB_CH0_PRIORITY_EN
        exp_fair = '{0, 0, 0, 0, 0};
        exp_prio = '{0, 0, 0, 0};
`else
        exp_fair = '{0, 1, 2, 3, 0};
        exp_prio = '{0, 3, 0, 3};
`endif

        // Power-on reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", 64'({mem_cs_n, mem_adv_n, mem_we_n, mem_oe_n}), 64'(4'b1111));
        check("rst_ctrl", 64'({ack, busy, mem_dq_oe}), 64'(0));
        check("rst_data", 64'({rdata, mem_addr, mem_dq_o}), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Reset in the middle of a write.
        issue(0, 1'b1, 24'h000020, 16'h1111);
        repeat (4) @(posedge clk);
        #1;
        check("t1_we_active", 64'(mem_we_n), 64'(0));
        rst_n = 1'b0; req = '0;
        @(posedge clk); @(negedge clk);
        check("t1_strobes", 64'({mem_cs_n, mem_we_n, mem_oe_n}), 64'(3'b111));
        check("t1_ctrl", 64'({mem_dq_oe, ack, busy}), 64'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        nack = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack != '0) nack++;
        end
        check("t1_no_ack", 64'(nack), 64'(0));

        // Isolated single accesses.
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i].ch, tbl[i].wr, tbl[i].a, tbl[i].wd);
            t0 = cyc; n_oe = 0; n_we = 0; n_dq = 0; seen = 1'b0;
            got_ack = '0; lat = 0; got_rd = '0; got_dq = '0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (!mem_oe_n) n_oe++;
                if (!mem_we_n) n_we++;
                if (mem_dq_oe) n_dq++;
                if (ack != '0) begin
                    seen = 1'b1; got_ack = ack; lat = cyc - t0; got_rd = rdata; got_dq = mem_dq_o;
                end
            end
            @(posedge clk); #1 req = '0;
            check($sformatf("v%0d_seen", i), 64'(seen), 64'(1));
            check($sformatf("v%0d_ack", i), 64'(got_ack), 64'(tbl[i].ack));
            check($sformatf("v%0d_lat", i), 64'(lat), 64'(W + 2));
            check($sformatf("v%0d_rdata", i), 64'(got_rd), 64'(tbl[i].rd));
            check($sformatf("v%0d_oe_cycles", i), 64'(n_oe), 64'(tbl[i].wr ? 0 : W));
            check($sformatf("v%0d_we_cycles", i), 64'(n_we), 64'(tbl[i].wr ? W : 0));
            check($sformatf("v%0d_dqoe_cycles", i), 64'(n_dq), 64'(tbl[i].wr ? W + 2 : 0));
            if (tbl[i].wr) check($sformatf("v%0d_dq_o", i), 64'(got_dq), 64'(tbl[i].wd));
        end

        // Early drop: ch3 releases req and changes its inputs during SETUP.
        issue(3, 1'b0, 24'h000010, 16'h0000);
        t0 = cyc;
        @(posedge clk); #1;
        req = '0; we[3] = 1'b1; addr[3*ADDR_W +: ADDR_W] = 24'hFFFFFF;
        wait_ack(a, at, ok);
        check("drop_seen", 64'(ok), 64'(1));
        check("drop_ack", 64'(a), 64'(4'b1000));
        check("drop_lat", 64'(at - t0), 64'(W + 2));
        check("drop_rdata", 64'(rdata), 64'(16'hA5A5));
        @(negedge clk);
        check("drop_idle", 64'(busy), 64'(0));

        // All four channels requesting permanently.
        reset_dut();
        for (int i = 0; i < NUM_CH; i++) addr[i*ADDR_W +: ADDR_W] = 24'(32'h100 + i);
        we = '0; req = 4'b1111; t0 = cyc; prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_ack(a, at, ok);
            check($sformatf("fair%0d_seen", n), 64'(ok), 64'(1));
            check($sformatf("fair%0d_ch", n), 64'(a), 64'(4'b0001 << exp_fair[n]));
            if (n == 0) check("fair_first_lat", 64'(at - t0), 64'(W + 2));
            else        check($sformatf("fair%0d_gap", n), 64'(at - prev), 64'(W + 3));
            prev = at;
        end
        @(posedge clk); #1 req = '0;

        // Channels 0 and 3 competing.
        reset_dut();
        req = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            wait_ack(a, at, ok);
            check($sformatf("prio%0d_seen", n), 64'(ok), 64'(1));
            check($sformatf("prio%0d_ch", n), 64'(a), 64'(4'b0001 << exp_prio[n]));
        end
        @(posedge clk); #1 req = '0;

        // Randomized traffic; the monitor checks every cycle.
        pend = '0;
        for (int c = 0; c < 700; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (pend[i]) begin
                    if (ack[i]) begin
                        pend[i] = 1'b0; req[i] = 1'b0;
                    end
                end else if (c < 550 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    we[i] = 1'($urandom_range(0, 1));
                    addr[i*ADDR_W +: ADDR_W] = 24'($urandom_range(0, 7));
                    wdata[i*DATA_W +: DATA_W] = 16'($urandom);
                    req[i] = 1'b1;
                end
            end
            if (c >= 550 && pend == '0) break;
        end
        check("rand_drain", 64'(pend), 64'(0));
        repeat (3) @(negedge clk);
        check("final_idle", 64'({busy, ack}), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
